// File: rtl/disp_pkg.sv
// Shared constants for the VRAM display/draw paths.
// Both the display read controller and the fill-rectangle writer use the
// same 64-bit HP port format: 16-beat INCR bursts of 128 bytes, with the
// VRAM window selected by a fixed 3-bit address prefix.
package disp_pkg;

  localparam int          BURST_LEN   = 16;
  localparam logic [7:0]  AXI_AWLEN   = 8'h0f;
  localparam logic [2:0]  AXI_AWSIZE  = 3'b011;
  localparam logic [1:0]  AXI_INCR    = 2'b01;
  localparam logic [3:0]  AXI_CACHE   = 4'b0011;
  localparam int          BURST_BYTES = 128;
  localparam int          BURST_SHIFT = 7;
  localparam logic [2:0]  VRAM_PREFIX = 3'b001;
  localparam logic [3:0]  BEAT_LAST   = 4'(BURST_LEN - 1);

  // Write-master sequencing: one burst outstanding at a time.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_B,
    ST_NEXT
  } state_e;

endpackage

// File: rtl/draw_addrgen.sv
// Burst address generator for the rectangle fill.
// Holds the current line start address, burst-in-line counter and line
// counter. load_i captures the geometry (low 7 bits of base/stride forced to
// zero so every burst is 128-byte aligned); step_i advances to the next burst.
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   load_i             capture base/stride/wbursts/height, zero the counters
//   step_i             move to the next burst (next line when the row is done)
//   base_i, stride_i   byte offset of top-left, line pitch in bytes
//   wbursts_i          bursts per line, height_i lines
//   addr_o             29-bit window offset of the current burst
//   last_o             current burst is the final burst of the final line
module draw_addrgen
  import disp_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic        step_i,
  input  logic [28:0] base_i,
  input  logic [15:0] stride_i,
  input  logic [5:0]  wbursts_i,
  input  logic [10:0] height_i,
  output logic [28:0] addr_o,
  output logic        last_o
);

  logic [28:0] line_addr_q, line_addr_d;
  logic [15:0] stride_q, stride_d;
  logic [5:0]  wbursts_q, wbursts_d;
  logic [10:0] height_q, height_d;
  logic [5:0]  bcnt_q, bcnt_d;
  logic [10:0] lcnt_q, lcnt_d;
  logic        row_more;

  // The low address bits never matter: bursts are always 128-byte aligned.
  logic unused_ok;
  assign unused_ok = ^{base_i[6:0], stride_i[6:0]};

  // Widened by one bit so WBURSTS=63 / HEIGHT=2047 compare correctly.
  assign row_more = ({1'b0, bcnt_q} + 7'd1) < {1'b0, wbursts_q};
  assign last_o   = !row_more &&
                    (({1'b0, lcnt_q} + 12'd1) >= {1'b0, height_q});

  // Address sums wrap modulo 2^29, keeping accesses inside the window.
  assign addr_o = line_addr_q + (29'(bcnt_q) << BURST_SHIFT);

  always_comb begin
    line_addr_d = line_addr_q;
    stride_d    = stride_q;
    wbursts_d   = wbursts_q;
    height_d    = height_q;
    bcnt_d      = bcnt_q;
    lcnt_d      = lcnt_q;
    if (load_i) begin
      line_addr_d = {base_i[28:7], 7'b0};
      stride_d    = {stride_i[15:7], 7'b0};
      wbursts_d   = wbursts_i;
      height_d    = height_i;
      bcnt_d      = '0;
      lcnt_d      = '0;
    end else if (step_i) begin
      if (row_more) begin
        bcnt_d = bcnt_q + 6'd1;
      end else begin
        bcnt_d      = '0;
        line_addr_d = line_addr_q + 29'(stride_q);
        lcnt_d      = lcnt_q + 11'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      line_addr_q <= '0;
      stride_q    <= '0;
      wbursts_q   <= '0;
      height_q    <= '0;
      bcnt_q      <= '0;
      lcnt_q      <= '0;
    end else begin
      line_addr_q <= line_addr_d;
      stride_q    <= stride_d;
      wbursts_q   <= wbursts_d;
      height_q    <= height_d;
      bcnt_q      <= bcnt_d;
      lcnt_q      <= lcnt_d;
    end
  end

endmodule

// File: rtl/draw_fillrect.sv
// AXI write master that fills a VRAM rectangle with one constant XRGB colour.
// Each 64-bit beat carries two pixels; each 16-beat INCR burst covers 32
// pixels (128 bytes). Exactly one burst is in flight: AW, then 16 W beats,
// then the B response, then one cycle to advance the address generator.
// Ports:
//   ACLK, ARST         clock, synchronous active-high reset
//   START              one-cycle command pulse (ignored while BUSY)
//   BASEADDR, STRIDE   rectangle top-left offset and line pitch (bytes)
//   WBURSTS, HEIGHT    width in 32-pixel bursts, height in lines
//   COLOR              fill pixel
//   BUSY, DONE, ERR    status: in progress, completion pulse, sticky BRESP error
//   M_AXI_AW*/W*/B*    AXI4 write channels
module draw_fillrect
  import disp_pkg::*;
#(
  parameter int C_M_AXI_THREAD_ID_WIDTH = 1,
  parameter int C_M_AXI_ADDR_WIDTH      = 32,
  parameter int C_M_AXI_DATA_WIDTH      = 64,
  parameter int C_M_AXI_AWUSER_WIDTH    = 1,
  parameter int C_M_AXI_WUSER_WIDTH     = 8,
  parameter int C_M_AXI_BUSER_WIDTH     = 1
) (
  input  logic                               ACLK,
  input  logic                               ARST,
  input  logic                               START,
  input  logic [28:0]                        BASEADDR,
  input  logic [15:0]                        STRIDE,
  input  logic [5:0]                         WBURSTS,
  input  logic [10:0]                        HEIGHT,
  input  logic [31:0]                        COLOR,
  output logic                               BUSY,
  output logic                               DONE,
  output logic                               ERR,
  output logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_AWID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]      M_AXI_AWADDR,
  output logic [7:0]                         M_AXI_AWLEN,
  output logic [2:0]                         M_AXI_AWSIZE,
  output logic [1:0]                         M_AXI_AWBURST,
  output logic                               M_AXI_AWLOCK,
  output logic [3:0]                         M_AXI_AWCACHE,
  output logic [2:0]                         M_AXI_AWPROT,
  output logic [3:0]                         M_AXI_AWQOS,
  output logic [C_M_AXI_AWUSER_WIDTH-1:0]    M_AXI_AWUSER,
  output logic                               M_AXI_AWVALID,
  input  logic                               M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]      M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]    M_AXI_WSTRB,
  output logic                               M_AXI_WLAST,
  output logic [C_M_AXI_WUSER_WIDTH-1:0]     M_AXI_WUSER,
  output logic                               M_AXI_WVALID,
  input  logic                               M_AXI_WREADY,
  input  logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_BID,
  input  logic [1:0]                         M_AXI_BRESP,
  input  logic [C_M_AXI_BUSER_WIDTH-1:0]     M_AXI_BUSER,
  input  logic                               M_AXI_BVALID,
  output logic                               M_AXI_BREADY
);

  state_e      state_q, state_d;
  logic [3:0]  beat_q, beat_d;
  logic [31:0] color_q, color_d;
  logic        err_q, err_d;
  logic        done_q, done_d;
  logic        ag_load, ag_step, ag_last;
  logic [28:0] ag_addr;
  logic        zero_size;

  // Single-ID master: the write response ID and user fields carry no information.
  logic unused_ok;
  assign unused_ok = ^{M_AXI_BID, M_AXI_BUSER};

  assign zero_size = (WBURSTS == 6'd0) || (HEIGHT == 11'd0);

  draw_addrgen u_addrgen (
    .clk_i     (ACLK),
    .rst_i     (ARST),
    .load_i    (ag_load),
    .step_i    (ag_step),
    .base_i    (BASEADDR),
    .stride_i  (STRIDE),
    .wbursts_i (WBURSTS),
    .height_i  (HEIGHT),
    .addr_o    (ag_addr),
    .last_o    (ag_last)
  );

  // Zero-size commands never leave IDLE: they clear ERR and pulse DONE
  // without touching the bus. The address generator is only loaded from
  // IDLE, so a START while busy cannot disturb the latched geometry.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    color_d = color_q;
    err_d   = err_q;
    done_d  = 1'b0;
    ag_load = 1'b0;
    ag_step = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          color_d = COLOR;
          err_d   = 1'b0;
          ag_load = 1'b1;
          if (zero_size) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_AW;
          end
        end
      end
      ST_AW: begin
        if (M_AXI_AWREADY) begin
          beat_d  = '0;
          state_d = ST_W;
        end
      end
      ST_W: begin
        if (M_AXI_WREADY) begin
          beat_d = beat_q + 4'd1;
          if (beat_q == BEAT_LAST) begin
            state_d = ST_B;
          end
        end
      end
      ST_B: begin
        if (M_AXI_BVALID) begin
          err_d   = err_q | (M_AXI_BRESP != 2'b00);
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (ag_last) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          ag_step = 1'b1;
          state_d = ST_AW;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARST) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      color_q <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      color_q <= color_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign BUSY = (state_q != ST_IDLE);
  assign DONE = done_q;
  assign ERR  = err_q;

  assign M_AXI_AWID    = '0;
  assign M_AXI_AWADDR  = C_M_AXI_ADDR_WIDTH'({VRAM_PREFIX, ag_addr});
  assign M_AXI_AWLEN   = AXI_AWLEN;
  assign M_AXI_AWSIZE  = AXI_AWSIZE;
  assign M_AXI_AWBURST = AXI_INCR;
  assign M_AXI_AWLOCK  = 1'b0;
  assign M_AXI_AWCACHE = AXI_CACHE;
  assign M_AXI_AWPROT  = '0;
  assign M_AXI_AWQOS   = '0;
  assign M_AXI_AWUSER  = '0;
  assign M_AXI_AWVALID = (state_q == ST_AW);

  assign M_AXI_WDATA  = C_M_AXI_DATA_WIDTH'({color_q, color_q});
  assign M_AXI_WSTRB  = '1;
  assign M_AXI_WUSER  = '0;
  assign M_AXI_WVALID = (state_q == ST_W);
  assign M_AXI_WLAST  = (state_q == ST_W) && (beat_q == BEAT_LAST);

  assign M_AXI_BREADY = (state_q == ST_B);

endmodule

// File: doc/draw_fillrect.md
Name: draw_fillrect

Overview:
- AXI write master that fills a rectangle of the VRAM frame buffer with one constant 32-bit XRGB colour, producing the frames that the display read path later scans out.
- Sits upstream of the display path on the same VRAM window (0x20000000–0x3FFFFFFF) and shares the 64-bit HP port format: 2 pixels per beat, 16-beat INCR bursts of 128 bytes.
- Commanded by a register block through a START pulse plus latched geometry. Reports BUSY, DONE and ERR.

Parameters:
- C_M_AXI_THREAD_ID_WIDTH, 1, AWID width.
- C_M_AXI_ADDR_WIDTH, 32, AWADDR width.
- C_M_AXI_DATA_WIDTH, 64, WDATA width (fixed 64; other values unsupported).
- C_M_AXI_AWUSER_WIDTH, 1, AWUSER width.
- C_M_AXI_WUSER_WIDTH, 8, WUSER width.
- C_M_AXI_BUSER_WIDTH, 1, BUSER width.

Ports:
- ACLK  in  1  AXI/system clock; the only clock.
- ARST  in  1  reset, synchronous, active-high.
- START  in  1  one-cycle command pulse.
- BASEADDR  in  29  byte offset of the rectangle top-left inside the VRAM window; bits [6:0] ignored (treated as 0).
- STRIDE  in  16  line pitch in bytes; bits [6:0] ignored.
- WBURSTS  in  6  rectangle width in 32-pixel bursts.
- HEIGHT  in  11  rectangle height in lines.
- COLOR  in  32  fill pixel, XRGB.
- BUSY  out  1  command in progress.
- DONE  out  1  one-cycle completion pulse.
- ERR  out  1  sticky: a BRESP other than OKAY was seen.
- M_AXI_AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWLOCK/AWCACHE/AWPROT/AWQOS/AWUSER/AWVALID  out; M_AXI_AWREADY  in.
- M_AXI_WDATA/WSTRB/WLAST/WUSER/WVALID  out; M_AXI_WREADY  in.
- M_AXI_BID/BRESP/BUSER/BVALID  in; M_AXI_BREADY  out.

Behaviour:
- Constant AXI outputs:
  - AWID=0, AWLEN=8'h0f, AWSIZE=3'b011, AWBURST=INCR, AWLOCK=0, AWCACHE=4'b0011, AWPROT=0, AWQOS=0, AWUSER=0, WUSER=0.
  - WSTRB=8'hff.
  - WDATA={COLOR_l, COLOR_l}, where COLOR_l is the value latched at START.
  - AWADDR={3'b001, addr[28:0]}.
- Reset values: BUSY=0, DONE=0, ERR=0, AWVALID=0, WVALID=0, WLAST=0, BREADY=0, state=IDLE.
- Command capture:
  - START in IDLE latches BASEADDR, STRIDE, WBURSTS, HEIGHT and COLOR, clears ERR, and sets BUSY on the next cycle.
  - START while BUSY is ignored, and the latched values are not disturbed.
  - Zero size (WBURSTS==0 or HEIGHT==0): no AXI traffic. DONE pulses 1 cycle after START, BUSY stays 0, ERR is cleared.
- FSM states and transitions:
  - IDLE: on START with nonzero size, go to AW.
  - AW: AWVALID=1 with addr = line_addr + bcnt*128, held stable until AWREADY. On handshake, go to W.
  - W: WVALID=1. A beat counter 0..15 advances on WVALID&WREADY. WLAST=1 when the count is 15. After the last-beat handshake, go to B.
  - B: BREADY=1. On BVALID, ERR |= (BRESP!=0), then go to NEXT.
  - NEXT: compute the next burst in 1 cycle.
    - If bcnt+1 < WBURSTS: bcnt++.
    - Else: bcnt=0, line_addr += STRIDE, lcnt++.
    - If the final burst of the final line is complete: DONE=1 for 1 cycle, BUSY=0, go to IDLE.
    - Otherwise go to AW.
- Transaction ordering: exactly one burst is outstanding. AW is never issued before the previous B has been received, and WVALID is never raised before the AW handshake.
- Arithmetic:
  - Address sums are 29-bit and wrap modulo 2^29, which keeps accesses inside the window.
  - bcnt is 6 bits, lcnt is 11 bits. lcnt is compared against HEIGHT.
- Ready/valid signals that are already high when VALID rises are accepted in that same cycle; no bubble is required.
- ARST mid-operation: all state and outputs return to their reset values on the next edge, and the in-flight burst is abandoned. The system guarantees the interconnect is reset at the same time.
- DONE and ERR: ERR stays valid after DONE until the next START.

Decomposition:
- Shared package (disp_pkg) holds:
  - burst length 16 and AWLEN 8'h0f
  - AWSIZE 3'b011
  - burst bytes 128
  - VRAM window prefix 3'b001
  - the FSM state enum
- These constants are shared with the display read controller.
- One natural sub-module: draw_addrgen, holding the line/burst counters and the address adder. It is controlled by load and step inputs and provides addr and last outputs.

Test Plan:
- BASEADDR=0x0000100, STRIDE=0x1400, WBURSTS=2, HEIGHT=2, AWREADY/WREADY/BVALID always ready -> AWADDR sequence 0x20000100, 0x20000180, 0x20001500, 0x20001580. Each burst has 16 beats with WLAST on beat 16. DONE pulses once and BUSY returns to 0.
- Random backpressure on AWREADY, WREADY and BVALID (0–7 cycle stalls) -> AWADDR and WDATA held stable while VALID is high. No AW is issued before the prior B. Total beats equal 16*WBURSTS*HEIGHT.
- BRESP=2'b10 on the second of 4 bursts -> ERR=1 from then on and the remaining bursts still complete. The next START clears ERR.
- WBURSTS=0 (or HEIGHT=0) -> DONE one cycle after START, AWVALID never asserts.
- START pulsed again mid-fill, plus BASEADDR=0x1FFFFF80 with HEIGHT=2 and STRIDE=0x80 -> the second START is ignored. The second line address wraps to AWADDR 0x20000000.
- ARST asserted during W state -> next cycle AWVALID=WVALID=BREADY=BUSY=0 and state is IDLE. A new START then runs normally.
